// File: rtl/l2_mem_bridge_if.sv
// Signal bundle between the coherence-bus L2 request port, the bridge and the generic memory port.
// The bridge takes the slave view; the environment (bus controller plus memory) takes the master view.
interface l2_mem_bridge_if;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [31:0] l2store;
  logic [3:0]  l2_byte_en;
  logic [1:0]  l2state;
  logic [31:0] l2load;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_error;

  modport slave (
    input  l2REN, l2WEN, l2addr, l2store, l2_byte_en, mem_rdata, mem_busy, mem_error,
    output l2state, l2load, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output l2REN, l2WEN, l2addr, l2store, l2_byte_en, mem_rdata, mem_busy, mem_error,
    input  l2state, l2load, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/l2_mem_bridge.sv
// Bridges a single-word L2 request into one memory-port transaction, with address
// range/alignment checking and a busy-timeout watchdog. All outputs are registered.
module l2_mem_bridge #(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE       = 32'h0010_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            nRST,
  l2_mem_bridge_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            ren_q, ren_d;
  logic            wen_q, wen_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Window end is formed in 33 bits so a window touching 32'hFFFF_FFFF cannot wrap.
  logic [32:0] win_lo, win_hi, addr_ext;
  logic        addr_legal;

  assign win_lo     = {1'b0, MEM_BASE};
  assign win_hi     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  assign addr_ext   = {1'b0, bus.l2addr};
  assign addr_legal = (addr_ext >= win_lo) && (addr_ext < win_hi) && (bus.l2addr[1:0] == 2'b00);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      L2_FREE: begin
        cnt_d = '0;
        if (bus.l2REN && bus.l2WEN) begin
          state_d = L2_ERROR;
        end else if (bus.l2REN || bus.l2WEN) begin
          if (!addr_legal) begin
            state_d = L2_ERROR;
          end else begin
            state_d = L2_BUSY;
            ren_d   = bus.l2REN;
            wen_d   = bus.l2WEN;
            addr_d  = bus.l2addr;
            wdata_d = bus.l2store;
            be_d    = bus.l2REN ? 4'hF : bus.l2_byte_en;
          end
        end
      end
      L2_BUSY: begin
        // A completing cycle (mem_busy low) takes priority over the watchdog.
        if (!bus.mem_busy) begin
          ren_d = 1'b0;
          wen_d = 1'b0;
          if (bus.mem_error) begin
            state_d = L2_ERROR;
          end else begin
            state_d = L2_ACCESS;
            if (ren_q) load_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = L2_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      L2_ACCESS, L2_ERROR: begin
        state_d = L2_FREE;
        cnt_d   = '0;
      end
      default: state_d = L2_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= L2_FREE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.l2state     = state_q;
  assign bus.l2load      = load_q;
  assign bus.mem_ren     = ren_q;
  assign bus.mem_wen     = wen_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_byte_en = be_q;

endmodule
